// File: rtl/hex_to_ascii_tx_if.sv
// Word-in / character-out handshake bundle for hex_to_ascii_tx.
// slave is the converter's view, master is the driver/consumer view.
interface hex_to_ascii_tx_if #(
  parameter int NIBBLES = 8
);
  logic                   word_valid;
  logic                   word_ready;
  logic [4*NIBBLES-1:0]   word_data;
  logic                   char_valid;
  logic                   char_ready;
  logic [7:0]             char_data;
  logic                   busy;

  modport slave (
    input  word_valid, word_data, char_ready,
    output word_ready, char_valid, char_data, busy
  );

  modport master (
    output word_valid, word_data, char_ready,
    input  word_ready, char_valid, char_data, busy
  );
endinterface

// File: rtl/hex_to_ascii_tx.sv
// Word -> ASCII hex chars (MS nibble first, CR, LF); "0x" prefix when HEX_TO_ASCII_TX_PREFIX_EN is defined.
// First char one cycle after capture; each char held until char_ready; word_ready only in IDLE.
module hex_to_ascii_tx #(
  parameter int NIBBLES   = 8,
  parameter bit UPPERCASE = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  hex_to_ascii_tx_if.slave bus
);

  localparam int W     = 4 * NIBBLES;
  localparam int CNT_W = $clog2(NIBBLES + 1);
  localparam logic [CNT_W-1:0] LAST_DIGIT = CNT_W'(NIBBLES - 1);

`ifdef HEX_TO_ASCII_TX_PREFIX_EN
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    PFX0  = 3'd1,
    PFX1  = 3'd2,
    DIGIT = 3'd3,
    CR    = 3'd4,
    LF    = 3'd5
  } state_e;
  localparam state_e FIRST_ST = PFX0;
`else
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    DIGIT = 3'd3,
    CR    = 3'd4,
    LF    = 3'd5
  } state_e;
  localparam state_e FIRST_ST = DIGIT;
`endif

  state_e           state_q, state_d;
  logic [W-1:0]     shift_q, shift_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             char_vld_q, char_vld_d;
  logic [7:0]       char_dat_q, char_dat_d;
  logic             char_hs;

  function automatic logic [7:0] enc_nib(input logic [3:0] n);
    if (n < 4'd10)  return 8'h30 + {4'h0, n};
    else if (UPPERCASE) return 8'h37 + {4'h0, n};
    else            return 8'h57 + {4'h0, n};
  endfunction

  assign char_hs        = char_vld_q && bus.char_ready;
  assign bus.word_ready = (state_q == IDLE);
  assign bus.busy       = (state_q != IDLE);
  assign bus.char_valid = char_vld_q;
  assign bus.char_data  = char_dat_q;

  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    cnt_d      = cnt_q;
    char_vld_d = char_vld_q;
    char_dat_d = char_dat_q;

    unique case (state_q)
      IDLE: begin
        if (bus.word_valid) begin
          shift_d = bus.word_data;
          cnt_d   = '0;
          state_d = FIRST_ST;
        end
      end
`ifdef HEX_TO_ASCII_TX_PREFIX_EN
      PFX0: if (char_hs) state_d = PFX1;
      PFX1: if (char_hs) state_d = DIGIT;
`endif
      DIGIT: begin
        if (char_hs) begin
          shift_d = shift_q << 4;
          if (cnt_q == LAST_DIGIT) begin
            cnt_d   = '0;
            state_d = CR;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      CR: if (char_hs) state_d = LF;
      LF: if (char_hs) state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // The output register is loaded with whatever the next state will show, so the
    // first character appears right after capture and advances with no bubbles.
    char_vld_d = (state_d != IDLE);
    unique case (state_d)
`ifdef HEX_TO_ASCII_TX_PREFIX_EN
      PFX0:    char_dat_d = 8'h30;
      PFX1:    char_dat_d = 8'h78;
`endif
      DIGIT:   char_dat_d = enc_nib(shift_d[W-1 -: 4]);
      CR:      char_dat_d = 8'h0D;
      LF:      char_dat_d = 8'h0A;
      default: char_dat_d = char_dat_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      shift_q    <= '0;
      cnt_q      <= '0;
      char_vld_q <= 1'b0;
      char_dat_q <= 8'h00;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      cnt_q      <= cnt_d;
      char_vld_q <= char_vld_d;
      char_dat_q <= char_dat_d;
    end
  end

endmodule

// File: tb/tb_hex_to_ascii_tx.sv
// Scoreboard bench: two converters (8 digits upper-case, 1 digit lower-case) against a string model.
module tb_hex_to_ascii_tx;

  localparam int NA = 8;
  localparam int NB = 1;
`ifdef HEX_TO_ASCII_TX_PREFIX_EN
  localparam int PFX = 2;
`else
  localparam int PFX = 0;
`endif

  logic clk;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;
  int   rdy_mode = 0;
  int unsigned cyc = 0;

  byte unsigned exp_a[$];
  byte unsigned exp_b[$];

  hex_to_ascii_tx_if #(.NIBBLES(NA)) a ();
  hex_to_ascii_tx_if #(.NIBBLES(NB)) b ();

  hex_to_ascii_tx #(.NIBBLES(NA), .UPPERCASE(1'b1)) u_a (.clk(clk), .rst_n(rst_n), .bus(a));
  hex_to_ascii_tx #(.NIBBLES(NB), .UPPERCASE(1'b0)) u_b (.clk(clk), .rst_n(rst_n), .bus(b));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic byte unsigned enc(input int nib, input bit upper);
    if (nib < 10) return byte'(48 + nib);
    return byte'((upper ? 65 : 97) + nib - 10);
  endfunction

  task automatic model_a(input logic [4*NA-1:0] w);
`ifdef HEX_TO_ASCII_TX_PREFIX_EN
    exp_a.push_back(8'h30);
    exp_a.push_back(8'h78);
`endif
    for (int i = NA - 1; i >= 0; i--) exp_a.push_back(enc(int'((w >> (4 * i)) & 4'hF), 1'b1));
    exp_a.push_back(8'h0D);
    exp_a.push_back(8'h0A);
  endtask

  task automatic model_b(input logic [4*NB-1:0] w);
`ifdef HEX_TO_ASCII_TX_PREFIX_EN
    exp_b.push_back(8'h30);
    exp_b.push_back(8'h78);
`endif
    for (int i = NB - 1; i >= 0; i--) exp_b.push_back(enc(int'((w >> (4 * i)) & 4'hF), 1'b0));
    exp_b.push_back(8'h0D);
    exp_b.push_back(8'h0A);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    case (rdy_mode)
      1: begin
        a.char_ready = 1'($urandom_range(0, 1));
        b.char_ready = 1'($urandom_range(0, 1));
      end
      2: begin
        a.char_ready = (cyc % 3 == 0);
        b.char_ready = (cyc % 3 == 0);
      end
      default: ;
    endcase
  endtask

  // word_valid is raised at once and held until the converter is back in IDLE.
  task automatic send_a(input logic [4*NA-1:0] w);
    int n = 0;
    a.word_valid = 1'b1;
    a.word_data  = w;
    model_a(w);
    while (!a.word_ready && n < 500) begin tick(); n++; end
    checks++;
    if (!a.word_ready) begin
      errors++;
      $display("FAIL send_a_timeout: word_ready=%0b required 1", a.word_ready);
    end else begin
      tick();
    end
    a.word_valid = 1'b0;
    a.word_data  = (4*NA)'($urandom);
  endtask

  task automatic send_b(input logic [4*NB-1:0] w);
    int n = 0;
    b.word_valid = 1'b1;
    b.word_data  = w;
    model_b(w);
    while (!b.word_ready && n < 500) begin tick(); n++; end
    checks++;
    if (!b.word_ready) begin
      errors++;
      $display("FAIL send_b_timeout: word_ready=%0b required 1", b.word_ready);
    end else begin
      tick();
    end
    b.word_valid = 1'b0;
    b.word_data  = (4*NB)'($urandom);
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_a.size() != 0 || exp_b.size() != 0 || a.busy || b.busy) && n < 3000) begin
      tick();
      n++;
    end
    checks++;
    if (exp_a.size() != 0 || exp_b.size() != 0 || a.busy || b.busy) begin
      errors++;
      $display("FAIL drain: pending a=%0d b=%0d busy=%0b%0b required 0 0 00",
               exp_a.size(), exp_b.size(), a.busy, b.busy);
    end
  endtask

  task automatic check_idle(input string name);
    checks++;
    if (a.char_valid !== 1'b0 || a.busy !== 1'b0 || a.word_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s: valid/busy/ready=%0b%0b%0b required 001", name,
               a.char_valid, a.busy, a.word_ready);
    end
  endtask

  // Scoreboard monitors: sampled on the falling edge, handshake completes on the next rising edge.
  logic       a_hold = 1'b0;
  logic [7:0] a_prev = 8'h00;
  always @(negedge clk) begin
    byte unsigned e;
    if (!rst_n) a_hold = 1'b0;
    if (a.char_valid && a_hold) begin
      checks++;
      if (a.char_data !== a_prev) begin
        errors++;
        $display("FAIL a_stable: char_data=%02h required %02h", a.char_data, a_prev);
      end
    end
    if (a.char_valid && a.char_ready) begin
      checks++;
      if (exp_a.size() == 0) begin
        errors++;
        $display("FAIL a_extra: char_data=%02h required no character", a.char_data);
      end else begin
        e = exp_a.pop_front();
        if (a.char_data !== e) begin
          errors++;
          $display("FAIL a_char: char_data=%02h required %02h", a.char_data, e);
        end
      end
    end
    a_hold = a.char_valid && !a.char_ready;
    a_prev = a.char_data;
  end

  logic       b_hold = 1'b0;
  logic [7:0] b_prev = 8'h00;
  always @(negedge clk) begin
    byte unsigned e;
    if (!rst_n) b_hold = 1'b0;
    if (b.char_valid && b_hold) begin
      checks++;
      if (b.char_data !== b_prev) begin
        errors++;
        $display("FAIL b_stable: char_data=%02h required %02h", b.char_data, b_prev);
      end
    end
    if (b.char_valid && b.char_ready) begin
      checks++;
      if (exp_b.size() == 0) begin
        errors++;
        $display("FAIL b_extra: char_data=%02h required no character", b.char_data);
      end else begin
        e = exp_b.pop_front();
        if (b.char_data !== e) begin
          errors++;
          $display("FAIL b_char: char_data=%02h required %02h", b.char_data, e);
        end
      end
    end
    b_hold = b.char_valid && !b.char_ready;
    b_prev = b.char_data;
  end

  initial begin
    rst_n        = 1'b0;
    a.word_valid = 1'b0;
    a.word_data  = '0;
    a.char_ready = 1'b0;
    b.word_valid = 1'b0;
    b.word_data  = '0;
    b.char_ready = 1'b0;
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b1;
    tick();

    // Reset state
    check_idle("reset_a");
    checks++;
    if (a.char_data !== 8'h00 || b.char_valid !== 1'b0 || b.busy !== 1'b0 || b.word_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_misc: a.data=%02h b.valid/busy/ready=%0b%0b%0b required 00 001",
               a.char_data, b.char_valid, b.busy, b.word_ready);
    end

    // Full-rate string: one char per cycle, busy throughout, ready again right after LF
    a.char_ready = 1'b1;
    send_a(32'hDEADBEEF);
    for (int k = 0; k < NA + 2 + PFX; k++) begin
      checks++;
      if (a.char_valid !== 1'b1 || a.busy !== 1'b1 || a.word_ready !== 1'b0) begin
        errors++;
        $display("FAIL burst_%0d: valid/busy/ready=%0b%0b%0b required 110", k,
                 a.char_valid, a.busy, a.word_ready);
      end
      tick();
    end
    check_idle("after_lf");
    drain();

    // All-zero word still prints every digit
    send_a(32'h0000_0000);
    drain();

    // Throttled consumer
    rdy_mode = 2;
    send_a(32'h01234567);
    drain();
    rdy_mode = 0;

    // Word offered mid-string waits for IDLE
    a.char_ready = 1'b1;
    send_a(32'h11111111);
    repeat (3) tick();
    send_a(32'h22222222);
    drain();

    // Reset mid-string clears outputs without a clock edge
    a.char_ready = 1'b0;
    send_a(32'hCAFEF00D);
    a.char_ready = 1'b1;
    repeat (3) tick();
    a.char_ready = 1'b0;
    #2 rst_n = 1'b0;
    #1 check_idle("async_reset");
    exp_a.delete();
    #8 rst_n = 1'b1;
    tick();
    check_idle("post_reset");
    a.char_ready = 1'b1;
    send_a(32'h00000001);
    drain();

    // Single-digit lower-case converter: every nibble value
    b.char_ready = 1'b1;
    for (int v = 0; v < 16; v++) send_b(4'(v));
    drain();

    // Randomised traffic on both converters with random backpressure
    rdy_mode = 1;
    for (int i = 0; i < 25; i++) begin
      send_a(32'($urandom));
      send_b(4'($urandom_range(0, 15)));
      repeat ($urandom_range(0, 3)) tick();
    end
    drain();
    rdy_mode = 0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/hex_to_ascii_tx.md
Name: hex_to_ascii_tx

Overview:
Converts a binary word into a printable ASCII hexadecimal string, one character at a time. Output order is most significant nibble first, then CR, then LF. It sits in the UART console between the command/response logic and the UART transmitter. It is the output-side counterpart of the console's ASCII-to-hex input decoding. Words arrive and characters leave on independent valid/ready handshakes.

Parameters:
NIBBLES, 8, number of hex digits printed per word; word width = 4*NIBBLES; legal range 1..16
UPPERCASE, 1, 1: digits A-F are encoded as 0x41-0x46; 0: digits a-f are encoded as 0x61-0x66

Ports:
clk  input  1  system clock; all logic is on the rising edge
rst_n  input  1  asynchronous active-low reset
word_valid  input  1  word_data is valid
word_ready  output  1  block can accept a word (high only in IDLE)
word_data  input  4*NIBBLES  value to print
char_valid  output  1  char_data is valid for the UART transmitter
char_ready  input  1  UART transmitter accepts char_data
char_data  output  8  ASCII character
busy  output  1  high while a string is in progress (any state except IDLE)

Behaviour:
- Reset is asynchronous and active-low: one clock, rst_n asynchronous active-low.
- Reset values: state=IDLE, char_valid=0, char_data=8'h00, busy=0, word_ready=1, digit counter=0, shift register=0.
- States: IDLE, [PFX0, PFX1 when the optional feature is compiled in], DIGIT, CR, LF.
- IDLE: word_ready=1.
  - On word_valid&&word_ready, word_data is captured into a shift register.
  - Next state is PFX0 if the feature is compiled in, else DIGIT.
  - word_ready drops the same cycle the state leaves IDLE.
- char_valid and char_data are registered outputs.
  - The first character is presented the cycle after word capture.
  - Once char_valid=1, char_data is held stable until char_valid&&char_ready.
- Each handshake advances to the next character on the following edge. With char_ready held high, the block emits one character per cycle with no bubbles inside a string.
- DIGIT:
  - Emits the top nibble of the shift register.
  - On handshake, shifts left by 4 and increments the counter.
  - After the NIBBLES-th digit handshake, goes to CR.
- Digit encoding: 0-9 map to 8'h30-8'h39. 10-15 map to 8'h41-8'h46 when UPPERCASE=1, else 8'h61-8'h66.
- CR: emits 8'h0D; on handshake goes to LF.
- LF: emits 8'h0A; on handshake goes to IDLE.
  - char_valid=0 in the following cycle and word_ready=1.
  - Consecutive strings are therefore separated by at least one idle cycle.
- Characters per word = NIBBLES+2, or NIBBLES+4 with the prefix feature.
- Boundaries:
  - word_valid while busy is ignored and does not disturb the string in progress.
  - Changes on word_data after capture have no effect.
  - char_ready while char_valid=0 is ignored.
  - A value of all zeros still prints NIBBLES '0' characters; no leading-zero suppression.
  - NIBBLES=1 gives exactly one digit and then CR, LF.
  - rst_n asserted mid-string: char_valid, busy and state clear immediately (asynchronously). No partial string resumes after reset is released.

Optional Feature:
Macro HEX_TO_ASCII_TX_PREFIX_EN.
- Defined: PFX0 emits 8'h30 ('0') and then PFX1 emits 8'h78 ('x') before the first digit. Each prefix character follows the same handshake rules as a digit.
- Undefined: PFX0 and PFX1 do not exist, and the first character after capture is the top digit.

Test Plan:
1. NIBBLES=8, UPPERCASE=1, word 32'hDEADBEEF, char_ready=1 -> 44 45 41 44 42 45 45 46 0D 0A on 10 consecutive cycles starting one cycle after capture. word_ready=0 and busy=1 throughout; word_ready=1 the cycle after the LF handshake.
2. UPPERCASE=0, word 32'h0000ABCF -> 30 30 30 30 61 62 63 66 0D 0A.
3. Word 32'h01234567 with char_ready high one cycle in three -> same 10 characters, none lost or duplicated. char_data is stable while char_valid=1 and char_ready=0.
4. Word 32'h11111111 accepted, then word_valid with 32'h22222222 after 3 characters -> only "11111111\r\n" is emitted. The second word is accepted only once word_ready returns high.
5. rst_n pulsed low after the 3rd character of 32'hCAFEF00D -> char_valid=0 with no clock edge required. After release, word_ready=1, and 32'h00000001 prints 30 30 30 30 30 30 30 31 0D 0A.
6. HEX_TO_ASCII_TX_PREFIX_EN defined, NIBBLES=4, word 16'h12AF -> 30 78 31 32 41 46 0D 0A (8 characters).
